// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display block.
// Segment bytes are active-high: bit0 = a ... bit6 = g, bit7 = dp (never lit).
package disp_pkg;

    // Blank digit: every segment off.
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Hex nibble to segment byte. Index with the nibble value; entry 0 is
    // the rightmost element of the concatenation.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71,  // F
        8'h79,  // E
        8'h5E,  // d
        8'h39,  // C
        8'h7C,  // b
        8'h77,  // A
        8'h6F,  // 9
        8'h7F,  // 8
        8'h07,  // 7
        8'h7D,  // 6
        8'h6D,  // 5
        8'h66,  // 4
        8'h4F,  // 3
        8'h5B,  // 2
        8'h06,  // 1
        8'h3F   // 0
    };

    // Widest value the leading-zero helper understands (64-bit values).
    localparam int LZ_MAX_DIGITS = 16;
    localparam int LZ_W          = LZ_MAX_DIGITS * 4;

    // Leading-zero blank mask for a right-aligned value of 'digits' nibbles.
    // Mask bit d refers to display digit d, where d = 0 is the most
    // significant nibble. A bit is set while every nibble from d = 0 down to
    // d is zero. The least significant digit is never masked, so a value of
    // zero still shows a single "0".
    function automatic logic [LZ_MAX_DIGITS-1:0] lz_blank_mask(
        input logic [LZ_W-1:0] value,
        input int              digits
    );
        logic [LZ_MAX_DIGITS-1:0] mask;
        logic                     still_zero;
        mask       = '0;
        still_zero = 1'b1;
        for (int d = 0; d < LZ_MAX_DIGITS; d++) begin
            if (d < digits - 1) begin
                if (value[(digits - 1 - d) * 4 +: 4] != 4'h0) begin
                    still_zero = 1'b0;
                end
                mask[d] = still_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/disp_hex_enc.sv
// Combinational encoder: one hex nibble plus a blank request in, one
// segment byte out. Blank wins over the nibble value.
module disp_hex_enc
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = blank ? SEG_BLANK : HEX_SEG[nibble];

endmodule

// File: rtl/disp_scan_mux.sv
// Multi-slot, multi-channel hex display latch with a time-multiplexed
// scanner. Producers write values into (slot, channel) storage; a divider
// paces a slot counter that walks every slot, and a registered output stage
// drives the segment bytes of the scanned slot together with a one-hot slot
// select.
//
// Write interface: wr_en is a plain strobe with no back-pressure. Every
// cycle with wr_en = 1 and an in-range (wr_slot, wr_ch) is accepted on that
// rising edge; out-of-range targets are dropped without side effects.
//
// Segment layout: byte k = ch*DIGITS + d sits at seg[k*8 +: 8]; d = 0 is the
// most significant nibble of the channel value.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int SLOTS    = 8,
    parameter int CHANS    = 2,
    parameter int VAL_W    = 16,
    parameter int SCAN_DIV = 1024
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         wr_en,
    input  logic [$clog2(SLOTS)-1:0]                     wr_slot,
    input  logic [((CHANS > 1) ? $clog2(CHANS) : 1)-1:0] wr_ch,
    input  logic [VAL_W-1:0]                             wr_data,
    input  logic                                         clr,
    input  logic                                         lz_en,
    output logic [CHANS*(VAL_W/4)*8-1:0]                 seg,
    output logic [SLOTS-1:0]                             slot_sel,
    output logic                                         frame_done
);

    localparam int DIGITS = VAL_W / 4;
    localparam int SEG_W  = CHANS * DIGITS * 8;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int CH_W   = (CHANS > 1) ? $clog2(CHANS) : 1;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W:0]   SLOT_LIMIT = (SLOT_W + 1)'(SLOTS);
    localparam logic [CH_W:0]     CH_LIMIT   = (CH_W + 1)'(CHANS);
    localparam logic [SLOTS-1:0]  SEL_FIRST  = SLOTS'(1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [VAL_W-1:0] store [SLOTS][CHANS];
    logic [CHANS-1:0] valid [SLOTS];
    logic             wr_hit;

    // Widen both indices by one bit so the range test also works when
    // SLOTS or CHANS is not a power of two.
    assign wr_hit = wr_en
                 && ({1'b0, wr_slot} < SLOT_LIMIT)
                 && ({1'b0, wr_ch}   < CH_LIMIT);

    // Value/flag storage: clear drops every flag first, a same-cycle write
    // then sets its own flag because the later assignment wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int c = 0; c < CHANS; c++) begin
                    store[s][c] <= '0;
                end
                valid[s] <= '0;
            end
        end else begin
            if (clr) begin
                for (int s = 0; s < SLOTS; s++) begin
                    valid[s] <= '0;
                end
            end
            if (wr_hit) begin
                store[wr_slot][wr_ch] <= wr_data;
                valid[wr_slot][wr_ch] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scanner: divider paces the slot counter
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] scan_slot;
    logic              wrap_flag;
    logic              div_tc;

    assign div_tc = (div_cnt == DIV_LAST);

    // Divider and slot counter; wrap_flag marks the cycle right after the
    // slot counter returns to 0 so frame_done lines up with slot_sel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            scan_slot <= '0;
            wrap_flag <= 1'b0;
        end else begin
            wrap_flag <= 1'b0;
            if (div_tc) begin
                div_cnt <= '0;
                if (scan_slot == SLOT_LAST) begin
                    scan_slot <= '0;
                    wrap_flag <= 1'b1;
                end else begin
                    scan_slot <= scan_slot + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment generation for the scanned slot
    // ------------------------------------------------------------------
    logic [VAL_W-1:0]  cur_val   [CHANS];
    logic [DIGITS-1:0] lz_mask   [CHANS];
    logic [CHANS-1:0]  cur_valid;
    logic [SEG_W-1:0]  seg_next;

    // Select the scanned slot's values and work out which leading digits
    // are zero; lz_en decides later whether that mask is honoured.
    always_comb begin
        cur_valid = valid[scan_slot];
        for (int c = 0; c < CHANS; c++) begin
            cur_val[c] = store[scan_slot][c];
            lz_mask[c] = DIGITS'(lz_blank_mask(LZ_W'(cur_val[c]), DIGITS));
        end
    end

    for (genvar c = 0; c < CHANS; c++) begin : g_ch
        for (genvar d = 0; d < DIGITS; d++) begin : g_dig
            logic [3:0] nibble;
            logic       blank;

            assign nibble = cur_val[c][(DIGITS - 1 - d) * 4 +: 4];
            assign blank  = !cur_valid[c] || (lz_en && lz_mask[c][d]);

            disp_hex_enc u_enc (
                .nibble (nibble),
                .blank  (blank),
                .seg    (seg_next[(c * DIGITS + d) * 8 +: 8])
            );
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    // seg and slot_sel come from the same scan_slot sample so they always
    // change on the same edge; reset forces slot 0 and blank segments.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg        <= '0;
            slot_sel   <= SEL_FIRST;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            slot_sel   <= SEL_FIRST << scan_slot;
            frame_done <= wrap_flag;
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux. Two instances: a main one (8 slots, 2 channels,
// divider 4) and a second one (10 slots, 1 channel, divider 1). Stimulus
// pushes expected output records {cycle, slot_sel, seg, frame_done}; the
// monitors pop one record each time the DUT presents a new display state.
module tb_disp_scan_mux;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic reset2;

  // Main DUT signals
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic        wr_ch;
  logic [15:0] wr_data;
  logic        clr;
  logic        lz_en;
  logic [63:0] seg;
  logic [7:0]  slot_sel;
  logic        frame_done;

  // Second DUT signals
  logic        wr2_en;
  logic [3:0]  wr2_slot;
  logic        wr2_ch;
  logic [15:0] wr2_data;
  logic        clr2;
  logic        lz2_en;
  logic [31:0] seg2;
  logic [9:0]  slot_sel2;
  logic        frame_done2;

  disp_scan_mux #(.SLOTS(8), .CHANS(2), .VAL_W(16), .SCAN_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .clr        (clr),
    .lz_en      (lz_en),
    .seg        (seg),
    .slot_sel   (slot_sel),
    .frame_done (frame_done)
  );

  disp_scan_mux #(.SLOTS(10), .CHANS(1), .VAL_W(16), .SCAN_DIV(1)) dut2 (
    .clock      (clock),
    .reset      (reset2),
    .wr_en      (wr2_en),
    .wr_slot    (wr2_slot),
    .wr_ch      (wr2_ch),
    .wr_data    (wr2_data),
    .clr        (clr2),
    .lz_en      (lz2_en),
    .seg        (seg2),
    .slot_sel   (slot_sel2),
    .frame_done (frame_done2)
  );

  // Cycle stamps: number of rising edges since reset was released.
  int cyc;
  int cyc2;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end
  always @(posedge clock or posedge reset2) begin
    if (reset2) cyc2 <= 0;
    else        cyc2 <= cyc2 + 1;
  end

  // ---------------- scoreboard ----------------
  localparam int EXP_W  = 16 + 8 + 64 + 1;
  localparam int EXP2_W = 16 + 10 + 32 + 1;
  logic [EXP_W-1:0]  exp_q[$];
  logic [EXP2_W-1:0] exp2_q[$];
  int checks = 0;
  int errors = 0;
  logic mon2_en = 1'b0;
  logic done2 = 1'b0;

  // Hand-computed segment images (byte k at bits [k*8 +: 8]).
  localparam logic [63:0] IMG_FULL0 = 64'h7179797C_664F5B06; // 1234 / BEEF
  localparam logic [63:0] IMG_CH0   = 64'h00000000_664F5B06; // 1234 only
  localparam logic [63:0] IMG_S3_A0 = 64'h3F770000_00000000; // ch1 00A0, lz
  localparam logic [63:0] IMG_S3_Z  = 64'h3F000000_00000000; // ch1 0000, lz
  localparam logic [63:0] IMG_S5    = 64'h00000000_073F3F3F; // ch0 0007
  localparam logic [63:0] IMG_S6    = 64'h5E3F3F71_00000000; // ch1 F00D
  localparam logic [31:0] IMG2_S9   = 32'h397C776F;          // 9ABC

  logic [63:0] img [8];

  task automatic exp_push(input int c, input logic [7:0] sel, input logic [63:0] s, input logic fd);
    exp_q.push_back({16'(c), sel, s, fd});
  endtask

  // One record per slot presentation: slot s appears at edge base + 4*s.
  task automatic push_range(input int base, input int first, input int last);
    for (int s = first; s <= last; s++) begin
      exp_push(base + 4 * s, 8'(1 << s), img[s], (s == 0));
    end
  endtask

  task automatic clear_img();
    for (int s = 0; s < 8; s++) img[s] = 64'h0;
  endtask

  // ---------------- monitors ----------------
  logic [71:0] prev1 = 'x;
  always @(negedge clock) begin
    logic [71:0]      cur;
    logic [EXP_W-1:0] e;
    cur = {slot_sel, seg};
    if (cur !== prev1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d sel=%h seg=%h fd=%b", cyc, slot_sel, seg, frame_done);
      end else begin
        e = exp_q.pop_front();
        if ({16'(cyc), slot_sel, seg, frame_done} !== e) begin
          errors++;
          $display("FAIL scan_output got cyc=%0d sel=%h seg=%h fd=%b expected cyc=%0d sel=%h seg=%h fd=%b",
                   cyc, slot_sel, seg, frame_done, e[88:73], e[72:65], e[64:1], e[0]);
        end
      end
    end else if (frame_done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL stray_frame_done cyc=%0d fd=%b expected 0", cyc, frame_done);
    end
    prev1 = cur;
  end

  logic [41:0] prev2 = 'x;
  always @(negedge clock) begin
    logic [41:0]       cur2;
    logic [EXP2_W-1:0] e2;
    cur2 = {slot_sel2, seg2};
    if (mon2_en && cur2 !== prev2) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output2 cyc=%0d sel=%h seg=%h", cyc2, slot_sel2, seg2);
      end else begin
        e2 = exp2_q.pop_front();
        if ({16'(cyc2), slot_sel2, seg2, frame_done2} !== e2) begin
          errors++;
          $display("FAIL scan_output2 got cyc=%0d sel=%h seg=%h fd=%b expected cyc=%0d sel=%h seg=%h fd=%b",
                   cyc2, slot_sel2, seg2, frame_done2, e2[58:43], e2[42:33], e2[32:1], e2[0]);
        end
      end
    end
    prev2 = cur2;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout cyc=%0d expected %0d", cyc, n);
    end
  endtask

  task automatic wait_cyc2(input int n);
    int guard = 0;
    while (cyc2 != n && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (cyc2 != n) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout2 cyc=%0d expected %0d", cyc2, n);
    end
  endtask

  // Present one write (optionally with clr) so it is sampled at edge_n.
  task automatic do_write(input int edge_n, input logic [2:0] s, input logic c,
                          input logic [15:0] d, input logic with_clr, input logic lz);
    wait_cyc(edge_n - 1);
    wr_en   = 1'b1;
    wr_slot = s;
    wr_ch   = c;
    wr_data = d;
    clr     = with_clr;
    lz_en   = lz;
    @(negedge clock);
    wr_en = 1'b0;
    clr   = 1'b0;
  endtask

  // ---------------- main DUT stimulus ----------------
  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_slot = '0;
    wr_ch   = 1'b0;
    wr_data = '0;
    clr     = 1'b0;
    lz_en   = 1'b0;
    clear_img();

    // Reset state, then frame 0: empty slots walk 02..80 every 4 cycles.
    exp_push(0, 8'h01, 64'h0, 1'b0);
    push_range(1, 1, 7);
    #32 reset = 1'b0;

    // Frame 1: wrap with frame_done, slot 0 written while on display.
    exp_push(33, 8'h01, 64'h0, 1'b1);
    exp_push(34, 8'h01, IMG_CH0, 1'b0);
    exp_push(35, 8'h01, IMG_FULL0, 1'b0);
    img[3] = IMG_S3_A0;
    push_range(33, 1, 7);
    do_write(33, 3'd0, 1'b0, 16'h1234, 1'b0, 1'b0);
    do_write(34, 3'd0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    do_write(40, 3'd3, 1'b1, 16'h00A0, 1'b0, 1'b1);

    // Frame 2: slot 3 ch1 rewritten to zero, lz keeps a single "0".
    img[0] = IMG_FULL0;
    img[3] = IMG_S3_Z;
    push_range(65, 0, 7);
    do_write(56, 3'd3, 1'b1, 16'h0000, 1'b0, 1'b1);

    // Frame 3: clr + write slot 5 in one cycle (after slot 0 shown), lz off.
    img[3] = 64'h0;
    img[5] = IMG_S5;
    img[6] = IMG_S6;
    push_range(97, 0, 7);
    do_write(100, 3'd5, 1'b0, 16'h0007, 1'b1, 1'b0);
    do_write(104, 3'd6, 1'b1, 16'hF00D, 1'b0, 1'b0);

    // Frame 4 up to slot 6, then asynchronous reset, then all blank.
    img[0] = 64'h0;
    push_range(129, 0, 6);
    exp_push(0, 8'h01, 64'h0, 1'b0);
    clear_img();
    push_range(1, 1, 7);
    push_range(33, 0, 7);

    wait_cyc(154);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;

    wait_cyc(63);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
    end

    begin
      int guard = 0;
      while (!done2 && guard < 200) begin
        @(negedge clock);
        guard++;
      end
      if (!done2) begin
        checks++;
        errors++;
        $display("FAIL dut2_timeout done=%b expected 1", done2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- second DUT stimulus (10 slots, divider 1) ----------------
  initial begin
    reset2   = 1'b1;
    wr2_en   = 1'b0;
    wr2_slot = '0;
    wr2_ch   = 1'b0;
    wr2_data = '0;
    clr2     = 1'b0;
    lz2_en   = 1'b0;

    // Slot (k-1) mod 10 is shown at edge k; slot 0 after a wrap has fd.
    for (int k = 11; k <= 30; k++) begin
      int s;
      s = (k - 1) % 10;
      exp2_q.push_back({16'(k), 10'(1 << s), (s == 9) ? IMG2_S9 : 32'h0, (s == 0)});
    end

    #32 reset2 = 1'b0;
    // Edge 1: top slot of a non-power-of-two scan.
    wr2_en   = 1'b1;
    wr2_slot = 4'd9;
    wr2_ch   = 1'b0;
    wr2_data = 16'h9ABC;
    @(negedge clock);
    // Edge 2: slot out of range, must be dropped.
    wr2_slot = 4'd12;
    wr2_data = 16'hFFFF;
    @(negedge clock);
    // Edge 3: channel out of range, must be dropped.
    wr2_slot = 4'd0;
    wr2_ch   = 1'b1;
    wr2_data = 16'h5555;
    @(negedge clock);
    wr2_en = 1'b0;
    wr2_ch = 1'b0;

    wait_cyc2(10);
    @(posedge clock);
    mon2_en = 1'b1;
    wait_cyc2(30);
    @(posedge clock);
    #1 mon2_en = 1'b0;
    checks++;
    if (exp2_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard2_drain left=%0d expected 0", exp2_q.size());
    end
    done2 = 1'b1;
  end

  // Watchdog against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog time=%0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
